// File: rtl/pc_branch_unit.sv
// Program-counter stage for the multicycle core: next-PC selection, beq/bne resolution,
// fetch/branch statistics. Optional PC trace FIFO enabled by defining PC_TRACE_EN.
module pc_branch_unit #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter int unsigned CNT_WIDTH   = 16,
   parameter int unsigned TRACE_DEPTH = 4
) (
   input  logic                 CLK,
   input  logic                 Reset,
   input  logic                 PCWrite,
   input  logic                 Branch,
   input  logic                 BranchNE,
   input  logic [1:0]           PCSrc,
   input  logic                 IRWrite,
   input  logic [15:0]          ALUResult,
   input  logic [15:0]          ALUOut,
   input  logic                 Zero,
   input  logic [11:0]          JumpField,
   input  logic [15:0]          RegA,
   input  logic                 FaultClear,
   input  logic                 TracePop,
   output logic [15:0]          PC,
   output logic [15:0]          CurPC,
   output logic                 Taken,
   output logic                 AlignFault,
   output logic [CNT_WIDTH-1:0] InstrCount,
   output logic [CNT_WIDTH-1:0] BranchCount,
   output logic [31:0]          TraceData,
   output logic                 TraceValid,
   output logic                 TraceOvf
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

   logic [15:0] target;
   logic [15:0] pc_load_val;
   logic        cond_met;
   logic        cond_taken;
   logic        load;

   always_comb begin
      target = ALUResult;
      unique case (PCSrc)
         2'd0: target = {PC[15:13], JumpField, 1'b0};
         2'd1: target = ALUResult;
         2'd2: target = ALUOut;
         2'd3: target = RegA;
         default: target = ALUResult;
      endcase
   end

   assign pc_load_val = {target[15:1], 1'b0};
   assign cond_met    = (Branch & Zero) | (BranchNE & ~Zero);
   assign cond_taken  = ~PCWrite & cond_met;
   assign load        = PCWrite | cond_met;

   always_ff @(posedge CLK) begin
      if (Reset) begin
         PC          <= RESET_PC;
         CurPC       <= 16'h0000;
         Taken       <= 1'b0;
         AlignFault  <= 1'b0;
         InstrCount  <= '0;
         BranchCount <= '0;
      end else begin
         if (load) PC <= pc_load_val;
         // A new fault outranks a simultaneous clear.
         if (load && target[0]) AlignFault <= 1'b1;
         else if (FaultClear)   AlignFault <= 1'b0;
         if (IRWrite) begin
            CurPC <= PC;
            if (InstrCount != '1) InstrCount <= InstrCount + CNT_ONE;
         end
         Taken <= cond_taken;
         if (cond_taken && (BranchCount != '1)) BranchCount <= BranchCount + CNT_ONE;
      end
   end

`ifdef PC_TRACE_EN
   localparam int unsigned AW = $clog2(TRACE_DEPTH);
   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [AW:0]   CNT1    = 1;
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(TRACE_DEPTH);

   logic [31:0]   trace_mem [TRACE_DEPTH];
   logic [AW-1:0] rd_ptr, rd_ptr_d, wr_ptr, wr_ptr_d;
   logic [AW:0]   trace_cnt, trace_cnt_d;
   logic [31:0]   entry, head_d;
   logic          push, pop, full;

   assign entry = {CurPC, pc_load_val};
   assign push  = load & (PCSrc != 2'd1);
   assign pop   = TracePop & (trace_cnt != '0);
   assign full  = (trace_cnt == FULL_CNT);

   always_comb begin
      rd_ptr_d    = rd_ptr;
      wr_ptr_d    = wr_ptr;
      trace_cnt_d = trace_cnt;
      head_d      = 32'h0;
      if (push) wr_ptr_d = wr_ptr + PTR_ONE;
      // Overwriting a full FIFO drops the oldest entry, same as a pop.
      if (pop || (push && full)) rd_ptr_d = rd_ptr + PTR_ONE;
      if (push && !pop && !full) trace_cnt_d = trace_cnt + CNT1;
      else if (pop && !push)     trace_cnt_d = trace_cnt - CNT1;
      if (trace_cnt_d != '0) begin
         if (push && (rd_ptr_d == wr_ptr)) head_d = entry;
         else                               head_d = trace_mem[rd_ptr_d];
      end
   end

   always_ff @(posedge CLK) begin
      if (!Reset && push) trace_mem[wr_ptr] <= entry;
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         trace_cnt  <= '0;
         TraceData  <= 32'h0;
         TraceValid <= 1'b0;
         TraceOvf   <= 1'b0;
      end else begin
         rd_ptr     <= rd_ptr_d;
         wr_ptr     <= wr_ptr_d;
         trace_cnt  <= trace_cnt_d;
         TraceData  <= head_d;
         TraceValid <= (trace_cnt_d != '0);
         if (push && full && !pop) TraceOvf <= 1'b1;
      end
   end
`else
   logic unused_trace;
   assign unused_trace = TracePop ^ (TRACE_DEPTH == 0);
   assign TraceData    = 32'h0;
   assign TraceValid   = 1'b0;
   assign TraceOvf     = 1'b0;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit; a second narrow-counter instance shares the
// stimulus to reach counter saturation quickly.
module tb_pc_branch_unit;

   logic        CLK = 1'b0;
   logic        Reset, PCWrite, Branch, BranchNE, IRWrite, Zero, FaultClear, TracePop;
   logic [1:0]  PCSrc;
   logic [15:0] ALUResult, ALUOut, RegA;
   logic [11:0] JumpField;

   logic [15:0] PC, CurPC;
   logic        Taken, AlignFault, TraceValid, TraceOvf;
   logic [15:0] InstrCount, BranchCount;
   logic [31:0] TraceData;

   logic [15:0] s_pc, s_cur_pc;
   logic        s_taken, s_fault, s_tvalid, s_tovf;
   logic [2:0]  s_icnt, s_bcnt;
   logic [31:0] s_tdata;

   int n_vec = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   pc_branch_unit #(.RESET_PC(16'h0000), .CNT_WIDTH(16), .TRACE_DEPTH(4)) dut (
      .CLK(CLK), .Reset(Reset), .PCWrite(PCWrite), .Branch(Branch), .BranchNE(BranchNE),
      .PCSrc(PCSrc), .IRWrite(IRWrite), .ALUResult(ALUResult), .ALUOut(ALUOut), .Zero(Zero),
      .JumpField(JumpField), .RegA(RegA), .FaultClear(FaultClear), .TracePop(TracePop),
      .PC(PC), .CurPC(CurPC), .Taken(Taken), .AlignFault(AlignFault),
      .InstrCount(InstrCount), .BranchCount(BranchCount), .TraceData(TraceData),
      .TraceValid(TraceValid), .TraceOvf(TraceOvf)
   );

   pc_branch_unit #(.RESET_PC(16'h0000), .CNT_WIDTH(3), .TRACE_DEPTH(4)) dut_s (
      .CLK(CLK), .Reset(Reset), .PCWrite(PCWrite), .Branch(Branch), .BranchNE(BranchNE),
      .PCSrc(PCSrc), .IRWrite(IRWrite), .ALUResult(ALUResult), .ALUOut(ALUOut), .Zero(Zero),
      .JumpField(JumpField), .RegA(RegA), .FaultClear(FaultClear), .TracePop(TracePop),
      .PC(s_pc), .CurPC(s_cur_pc), .Taken(s_taken), .AlignFault(s_fault),
      .InstrCount(s_icnt), .BranchCount(s_bcnt), .TraceData(s_tdata),
      .TraceValid(s_tvalid), .TraceOvf(s_tovf)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      Reset = 0; PCWrite = 0; Branch = 0; BranchNE = 0; IRWrite = 0; Zero = 0;
      FaultClear = 0; TracePop = 0; PCSrc = 2'd0; ALUResult = 16'h0; ALUOut = 16'h0;
      RegA = 16'h0; JumpField = 12'h0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      idle();
      Reset = 1;
      step();
      Reset = 0;
      chk("rst_pc", 32'(PC), 32'h0000);
      chk("rst_curpc", 32'(CurPC), 32'h0000);
      chk("rst_taken", 32'(Taken), 32'h0);
      chk("rst_fault", 32'(AlignFault), 32'h0);
      chk("rst_icnt", 32'(InstrCount), 32'h0);
      chk("rst_bcnt", 32'(BranchCount), 32'h0);
      chk("rst_tvalid", 32'(TraceValid), 32'h0);

      // Fetch: PC+2 loaded, CurPC captures pre-increment PC
      IRWrite = 1; PCWrite = 1; PCSrc = 2'd1; ALUResult = 16'h0002;
      step(); idle();
      chk("fetch_pc", 32'(PC), 32'h0002);
      chk("fetch_curpc", 32'(CurPC), 32'h0000);
      chk("fetch_icnt", 32'(InstrCount), 32'h1);

      PCWrite = 1; PCSrc = 2'd1; ALUResult = 16'h0010;
      step(); idle();
      chk("set_pc10", 32'(PC), 32'h0010);

      // beq taken
      Branch = 1; Zero = 1; PCSrc = 2'd2; ALUOut = 16'h0040;
      step(); idle();
      chk("beq_pc", 32'(PC), 32'h0040);
      chk("beq_taken", 32'(Taken), 32'h1);
      chk("beq_bcnt", 32'(BranchCount), 32'h1);
      step();
      chk("beq_pulse_end", 32'(Taken), 32'h0);

      // beq not taken
      Branch = 1; Zero = 0; PCSrc = 2'd2; ALUOut = 16'h0080;
      step(); idle();
      chk("beq_nt_pc", 32'(PC), 32'h0040);
      chk("beq_nt_taken", 32'(Taken), 32'h0);
      chk("beq_nt_bcnt", 32'(BranchCount), 32'h1);

      // bne taken
      BranchNE = 1; Zero = 0; PCSrc = 2'd2; ALUOut = 16'h0060;
      step(); idle();
      chk("bne_pc", 32'(PC), 32'h0060);
      chk("bne_taken", 32'(Taken), 32'h1);
      chk("bne_bcnt", 32'(BranchCount), 32'h2);

      // PCWrite with branch condition true: load but no taken pulse
      PCWrite = 1; Branch = 1; Zero = 1; PCSrc = 2'd1; ALUResult = 16'h0070;
      step(); idle();
      chk("pcw_br_pc", 32'(PC), 32'h0070);
      chk("pcw_br_taken", 32'(Taken), 32'h0);
      chk("pcw_br_bcnt", 32'(BranchCount), 32'h2);

      // Jump keeps PC[15:13]
      PCWrite = 1; PCSrc = 2'd1; ALUResult = 16'hA000;
      step(); idle();
      PCWrite = 1; PCSrc = 2'd0; JumpField = 12'h123;
      step(); idle();
      chk("jump_pc", 32'(PC), 32'hA246);

      // jr to odd address
      PCWrite = 1; PCSrc = 2'd3; RegA = 16'h0031;
      step(); idle();
      chk("jr_odd_pc", 32'(PC), 32'h0030);
      chk("jr_odd_fault", 32'(AlignFault), 32'h1);
      FaultClear = 1;
      step(); idle();
      chk("fault_clr", 32'(AlignFault), 32'h0);
      chk("fault_clr_pc", 32'(PC), 32'h0030);
      PCWrite = 1; PCSrc = 2'd3; RegA = 16'h0051;
      step(); idle();
      chk("fault_again", 32'(AlignFault), 32'h1);
      FaultClear = 1; PCWrite = 1; PCSrc = 2'd2; ALUOut = 16'h0101;
      step(); idle();
      chk("fault_set_wins", 32'(AlignFault), 32'h1);
      chk("fault_set_pc", 32'(PC), 32'h0100);

      // Counter saturation on the 3-bit instance
      for (int i = 0; i < 8; i++) begin
         IRWrite = 1;
         step();
      end
      idle();
      chk("icnt_main", 32'(InstrCount), 32'd9);
      chk("icnt_sat", 32'(s_icnt), 32'd7);
      for (int i = 0; i < 6; i++) begin
         Branch = 1; Zero = 1; PCSrc = 2'd2; ALUOut = 16'h0100;
         step();
      end
      idle();
      chk("bcnt_main", 32'(BranchCount), 32'd8);
      chk("bcnt_sat", 32'(s_bcnt), 32'd7);

      // Reset wins over a taken branch
      Reset = 1; Branch = 1; Zero = 1; PCSrc = 2'd2; ALUOut = 16'h0200;
      step(); idle();
      chk("rst_br_pc", 32'(PC), 32'h0000);
      chk("rst_br_taken", 32'(Taken), 32'h0);
      chk("rst_br_bcnt", 32'(BranchCount), 32'h0);
      chk("rst_br_icnt", 32'(InstrCount), 32'h0);
      chk("rst_br_fault", 32'(AlignFault), 32'h0);

`ifdef PC_TRACE_EN
      for (int i = 1; i <= 5; i++) begin
         PCWrite = 1; PCSrc = 2'd0; JumpField = 12'(i);
         step();
      end
      idle();
      chk("tr_ovf", 32'(TraceOvf), 32'h1);
      chk("tr_valid", 32'(TraceValid), 32'h1);
      chk("tr_head", TraceData, 32'h0000_0004);
      PCWrite = 1; PCSrc = 2'd0; JumpField = 12'h006; TracePop = 1;
      step(); idle();
      chk("tr_pp_ovf", 32'(TraceOvf), 32'h1);
      chk("tr_pp_head", TraceData, 32'h0000_0006);
      for (int i = 0; i < 3; i++) begin
         TracePop = 1;
         step();
         chk("tr_pop_head", TraceData, 32'(16'h0008 + 16'(2 * i)));
      end
      step(); idle();
      chk("tr_empty", 32'(TraceValid), 32'h0);
`else
      for (int i = 1; i <= 5; i++) begin
         PCWrite = 1; PCSrc = 2'd0; JumpField = 12'(i); TracePop = 1;
         step();
      end
      idle();
      chk("notr_pc", 32'(PC), 32'h000A);
      chk("notr_valid", 32'(TraceValid), 32'h0);
      chk("notr_data", TraceData, 32'h0);
      chk("notr_ovf", 32'(TraceOvf), 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
